pdm_decoder: RTL and testbench
==============================

Name: pdm_decoder

Overview:
- Receive-side counterpart of the 5-bit pulse-density modulator.
- Accepts a 1-bit PDM stream and recovers the multi-bit level by counting ones over a fixed boxcar window of 2^WIN_LOG2 enabled cycles, with decimation.
- Emits a registered DATA_W-bit sample plus a one-cycle valid strobe per window.
- Used for on-chip loopback of the modulator and for decoding external PDM sources through the 8-bit user io.

Parameters:
- DATA_W, 5: width of recovered sample.
- WIN_LOG2, 5: log2 of window length in enabled cycles. Must be >= DATA_W (checked by elaboration-time assertion).
- SYNC_STAGES, 2: flop stages synchronising pdm_in. Legal range 2..3.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pdm_in  in  1  PDM bitstream; asynchronous to clk, sampled after synchroniser.
- enable  in  1  window advance enable; low freezes window counter and accumulator.
- restart  in  1  synchronous pulse; discards partial window and starts a new one.
- data_out  out  DATA_W  last completed window result, held until next result.
- data_valid  out  1  one-cycle pulse when data_out updates.

Behaviour:
- Reset (async assert, sync-released by the system):
  - Sync flops, win_cnt, acc, data_out and data_valid all go to 0.
  - Reset mid-window discards all partial state. The first data_valid comes only after a full window following release.
- Synchroniser: pdm_in passes through SYNC_STAGES flops. The sample counted in a cycle (s_bit) is the last stage. The chain runs regardless of enable.
- Window counter win_cnt, WIN_LOG2 bits:
  - Increments by 1 on each cycle with enable=1 and restart=0.
  - Wraps from 2^WIN_LOG2-1 to 0.
- Accumulator acc, WIN_LOG2+1 bits:
  - On each enabled cycle: acc <= acc + s_bit.
  - On the last enabled cycle of a window (win_cnt = 2^WIN_LOG2-1): acc <= 0 and the total (acc + s_bit) is committed.
- Commit, registered:
  - data_out <= min(total >> (WIN_LOG2-DATA_W), 2^DATA_W-1).
  - A full window of ones saturates to all ones (31 with defaults). There is no wrap to 0.
  - data_valid = 1 for exactly the cycle after the last sample, i.e. data_out and data_valid change on the same edge.
- Latency: with enable held high from cycle 0 after restart or reset, data_valid asserts at cycle 2^WIN_LOG2. Input edges reach the count SYNC_STAGES cycles late.
- enable=0:
  - win_cnt, acc, data_out hold; data_valid stays 0.
  - The window resumes where it stopped. Disabled cycles do not count toward the window.
- restart=1:
  - win_cnt and acc cleared next edge; the current s_bit is not counted. data_out is held; no data_valid.
  - restart takes priority over enable and over a coincident commit: that window's result is dropped and data_valid stays 0.
- data_out is stable between strobes. There is no consumer handshake; a missed strobe is simply overwritten by the next window.

Decomposition:
- Shared package pdm_pkg:
  - PDM_DATA_W = 5 and PDM_WIN_LOG2 = 5, shared with the modulator so encoder and decoder agree on period.
  - A saturate-and-scale function, pdm_scale(total).
- One natural sub-module: pdm_sync (parameterised SYNC_STAGES bit synchroniser with async reset), reusable for the modulator's write_en path.
- The existing 8-bit user-module wrapper maps:
  - io_in[0] = clk, io_in[1] = reset, io_in[2] = pdm_in, io_in[3] = enable, io_in[4] = restart.
  - io_out[4:0] = data_out, io_out[5] = data_valid, io_out[7:6] = 0.

Test Plan:
1. Reset, enable=1, pdm_in=0 for 3 windows -> data_valid pulses every 32 cycles with data_out=0; first pulse exactly 32 cycles after reset release.
2. pdm_in constant 1, enable=1 -> after the sync-fill window, data_out=31 (saturated, not 0) each window; data_valid single-cycle.
3. Stream with 8 ones per 32 cycles (modulator output for 0x08), then 26 ones per 32 (0x1a), aligned to window start -> data_out=8, then 26 on successive strobes; held constant between strobes.
4. Alternating 1/0 stream; drop enable for 10 cycles mid-window -> strobe is delayed by exactly 10 cycles and data_out=16.
5. Assert restart at win_cnt=20 with 20 ones counted, then all-ones input -> no strobe at the old boundary; next strobe 32 cycles after restart with data_out=31; data_out holds its prior value until then. Repeat with restart coincident with the last sample -> no strobe.
6. Assert reset asynchronously mid-window (between clock edges) -> data_out=0 and data_valid=0 immediately; next strobe exactly 32 enabled cycles after release.

Source files
------------

// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared PDM period constants and the decoder's saturate-and-scale helper
package pdm_pkg;

    // Shared with the modulator so that the encoder period and the decoder window agree.
    localparam int PDM_DATA_W   = 5;
    localparam int PDM_WIN_LOG2 = 5;

    // Scale a window total down to the sample width and clamp it.
    // A full window of ones (2^WIN_LOG2) must read back as all ones rather than wrap to 0.
    function automatic logic [31:0] pdm_scale(input logic [31:0] total,
                                              input int          shift,
                                              input int          data_w);
        logic [31:0] scaled;
        logic [31:0] max_val;
        scaled  = total >> shift;
        max_val = (32'd1 << data_w) - 32'd1;
        return (scaled > max_val) ? max_val : scaled;
    endfunction

endpackage

// File: rtl/pdm_sync.sv
// rtl/pdm_sync.sv - multi-stage single-bit synchroniser with asynchronous reset
module pdm_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_stages
        $error("pdm_sync: SYNC_STAGES must be 2 or 3");
    end

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw input through the flop chain every cycle; the chain ignores enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pdm_decoder.sv
// rtl/pdm_decoder.sv - boxcar ones-counter that recovers a multi-bit level from a PDM stream
import pdm_pkg::*;

module pdm_decoder #(
    parameter int DATA_W      = PDM_DATA_W,
    parameter int WIN_LOG2    = PDM_WIN_LOG2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pdm_in,
    input  logic              enable,
    input  logic              restart,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid
);

    if (WIN_LOG2 < DATA_W) begin : g_bad_win
        $error("pdm_decoder: WIN_LOG2 must be >= DATA_W");
    end

    logic                s_bit;
    logic [WIN_LOG2-1:0] win_cnt;
    logic [WIN_LOG2:0]   acc;
    logic [WIN_LOG2:0]   total;
    logic                last_sample;

    pdm_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pdm_in),
        .q     (s_bit)
    );

    // Running count including this cycle's sample; acc is one bit wider so a full window fits.
    assign total       = acc + {{WIN_LOG2{1'b0}}, s_bit};
    assign last_sample = (win_cnt == {WIN_LOG2{1'b1}});

    // Window advance, accumulation and commit; restart outranks both enable and a pending commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt    <= '0;
            acc        <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (restart) begin
                win_cnt <= '0;
                acc     <= '0;
            end else if (enable) begin
                win_cnt <= win_cnt + WIN_LOG2'(1);
                if (last_sample) begin
                    acc        <= '0;
                    data_out   <= DATA_W'(pdm_scale(32'(total), WIN_LOG2 - DATA_W, DATA_W));
                    data_valid <= 1'b1;
                end else begin
                    acc <= total;
                end
            end
        end
    end

endmodule

// File: tb/tb_pdm_decoder.sv
// tb/tb_pdm_decoder.sv - directed self-checking bench for pdm_decoder
module tb_pdm_decoder;

    logic       clk;
    logic       reset;
    logic       pdm_in;
    logic       enable;
    logic       restart;
    logic [4:0] data_out;
    logic       data_valid;

    int n_checks = 0;
    int n_errors = 0;

    int         tick_n;
    int         gi;
    int         pulse_t[$];
    logic [4:0] pulse_v[$];
    logic [4:0] held;
    bit         stable_ok;
    bit         single_ok;
    logic       prev_valid;

    pdm_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .pdm_in     (pdm_in),
        .enable     (enable),
        .restart    (restart),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample #1 after the rising edge and log strobes / hold violations.
    task automatic tick();
        @(posedge clk);
        #1;
        tick_n++;
        if (data_valid === 1'b1) begin
            pulse_t.push_back(tick_n);
            pulse_v.push_back(data_out);
            held = data_out;
            if (prev_valid === 1'b1) single_ok = 1'b0;
        end else if (data_out !== held) begin
            stable_ok = 1'b0;
        end
        prev_valid = data_valid;
    endtask

    task automatic drive(input int n, input logic [31:0] pat);
        for (int i = 0; i < n; i++) begin
            pdm_in = pat[gi % 32];
            gi++;
            tick();
        end
    endtask

    task automatic mark();
        tick_n = 0;
        pulse_t.delete();
        pulse_v.delete();
        stable_ok = 1'b1;
        single_ok = 1'b1;
    endtask

    function automatic int get_t(input int k);
        return (k < pulse_t.size()) ? pulse_t[k] : -1;
    endfunction

    function automatic int get_v(input int k);
        return (k < pulse_v.size()) ? int'(pulse_v[k]) : -1;
    endfunction

    initial begin
        reset      = 1'b1;
        pdm_in     = 1'b0;
        enable     = 1'b1;
        restart    = 1'b0;
        gi         = 0;
        tick_n     = 0;
        held       = 5'd0;
        prev_valid = 1'b0;
        mark();

        // Reset state
        tick();
        tick();
        chk("reset_data_out", 32'(data_out), 0);
        chk("reset_data_valid", 32'(data_valid), 0);

        // 1: zeros for three windows, first strobe 32 cycles after release
        reset = 1'b0;
        mark();
        drive(96, 32'h0000_0000);
        chk("t1_npulse", pulse_t.size(), 3);
        chk("t1_t0", get_t(0), 32);
        chk("t1_t1", get_t(1), 64);
        chk("t1_t2", get_t(2), 96);
        chk("t1_v0", get_v(0), 0);
        chk("t1_v2", get_v(2), 0);

        // 2: constant ones; first window loses two samples to the synchroniser, then saturates
        mark();
        drive(64, 32'hFFFF_FFFF);
        chk("t2_npulse", pulse_t.size(), 2);
        chk("t2_fill_v", get_v(0), 30);
        chk("t2_sat_v", get_v(1), 31);
        chk("t2_single", 32'(single_ok), 1);

        // 3: 8 ones per window then 26 ones per window
        mark();
        drive(64, 32'h1111_1111);
        chk("t3_8_t", get_t(1), 64);
        chk("t3_8_v", get_v(1), 8);
        chk("t3_8_hold", 32'(stable_ok), 1);
        mark();
        drive(64, 32'hFFFF_FFC0);
        chk("t3_26_v", get_v(1), 26);
        chk("t3_26_hold", 32'(stable_ok), 1);

        // 4: alternating stream, enable dropped for 10 cycles mid-window
        drive(32, 32'hAAAA_AAAA);
        mark();
        drive(15, 32'hAAAA_AAAA);
        enable = 1'b0;
        drive(10, 32'hAAAA_AAAA);
        enable = 1'b1;
        drive(17, 32'hAAAA_AAAA);
        chk("t4_npulse", pulse_t.size(), 1);
        chk("t4_t", get_t(0), 42);
        chk("t4_v", get_v(0), 16);

        // 5a: restart at win_cnt=20, then all ones
        mark();
        drive(20, 32'hFFFF_FFFF);
        restart = 1'b1;
        drive(1, 32'hFFFF_FFFF);
        restart = 1'b0;
        drive(31, 32'hFFFF_FFFF);
        chk("t5_no_old_strobe", pulse_t.size(), 0);
        chk("t5_held", 32'(data_out), 16);
        drive(1, 32'hFFFF_FFFF);
        chk("t5_npulse", pulse_t.size(), 1);
        chk("t5_t", get_t(0), 53);
        chk("t5_v", get_v(0), 31);
        chk("t5_hold", 32'(stable_ok), 1);

        // 5b: restart coincident with the last sample drops that window
        mark();
        drive(31, 32'hFFFF_FFFF);
        restart = 1'b1;
        drive(1, 32'hFFFF_FFFF);
        restart = 1'b0;
        drive(31, 32'hFFFF_FFFF);
        chk("t5b_no_strobe", pulse_t.size(), 0);
        drive(1, 32'hFFFF_FFFF);
        chk("t5b_t", get_t(0), 64);
        chk("t5b_v", get_v(0), 31);

        // 6: asynchronous reset between edges mid-window
        mark();
        drive(10, 32'hFFFF_FFFF);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_async_data_out", 32'(data_out), 0);
        chk("t6_async_valid", 32'(data_valid), 0);
        held = 5'd0;
        drive(2, 32'hFFFF_FFFF);
        reset = 1'b0;
        mark();
        drive(40, 32'hFFFF_FFFF);
        chk("t6_npulse", pulse_t.size(), 1);
        chk("t6_t", get_t(0), 32);
        chk("t6_v", get_v(0), 30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
